// File: rtl/imu_pkg.sv
// Shared definitions for the MPU9250 burst reader: register map, SPI byte constants,
// burst length and the reader FSM encoding.
package imu_pkg;

    localparam logic [7:0] ACCEL_XOUT_H = 8'h3B;
    localparam logic [7:0] WHO_AM_I     = 8'h75;
    localparam logic [7:0] READ_BIT     = 8'h80;
    localparam logic [7:0] DUMMY_BYTE   = 8'h00;
    localparam int         BURST_LEN    = 14;
    localparam int         NUM_WORDS    = BURST_LEN / 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_RX = 2'd2,
        LATCH   = 2'd3
    } state_t;

    function automatic logic signed [15:0] be_word(input logic [7:0] hi, input logic [7:0] lo);
        return $signed({hi, lo});
    endfunction

endpackage

// File: rtl/imu_sample_timer.sv
// Free-running trigger source: one-cycle tick every SAMPLE_DIV clocks.
// Only instantiated when IMU_SAMPLE_TIMER_EN is defined.
module imu_sample_timer #(
    parameter int SAMPLE_DIV = 12000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [31:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 32'd0;
            tick  <= 1'b0;
        end else if (count == 32'(SAMPLE_DIV - 1)) begin
            count <= 32'd0;
            tick  <= 1'b1;
        end else begin
            count <= count + 32'd1;
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/imu_burst_reader.sv
// MPU9250 burst reader: command byte plus 14 dummy bytes through an SPI byte engine,
// assembled into seven signed words. Optional internal trigger: IMU_SAMPLE_TIMER_EN.
module imu_burst_reader
    import imu_pkg::*;
#(
    parameter logic [7:0] START_REG  = ACCEL_XOUT_H,
    parameter int         NUM_BYTES  = BURST_LEN,
    parameter int         SAMPLE_DIV = 12000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic [7:0]         spi_tx_byte,
    output logic               spi_tx_valid,
    input  logic               spi_tx_ready,
    input  logic [7:0]         spi_rx_byte,
    input  logic               spi_rx_valid,
    output logic               spi_cs_hold,
    output logic signed [15:0] accel_x,
    output logic signed [15:0] accel_y,
    output logic signed [15:0] accel_z,
    output logic signed [15:0] temp_raw,
    output logic signed [15:0] gyro_x,
    output logic signed [15:0] gyro_y,
    output logic signed [15:0] gyro_z,
    output logic               sample_valid
);

    if (NUM_BYTES != BURST_LEN) begin : g_len_check
        $error("imu_burst_reader: NUM_BYTES must be %0d", BURST_LEN);
    end
    if (SAMPLE_DIV < 1) begin : g_div_check
        $error("imu_burst_reader: SAMPLE_DIV must be positive");
    end

    state_t     state;
    logic [3:0] byte_cnt;
    logic [7:0] rx_buf   [BURST_LEN];
    logic [7:0] buf_next [BURST_LEN];
    logic       trigger;

`ifdef IMU_SAMPLE_TIMER_EN
    logic timer_tick;

    imu_sample_timer #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .tick (timer_tick)
    );

    assign trigger = start | timer_tick;
`else
    assign trigger = start;
`endif

    // Buffer as it will look after the current rx byte lands; lets the final byte
    // go straight into the output words on the same edge it arrives.
    always_comb begin
        buf_next = rx_buf;
        if (byte_cnt != 4'd0) begin
            buf_next[byte_cnt - 4'd1] = spi_rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (state == WAIT_RX && spi_rx_valid) begin
            rx_buf <= buf_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            spi_tx_valid <= 1'b0;
            spi_cs_hold  <= 1'b0;
            sample_valid <= 1'b0;
            spi_tx_byte  <= 8'h00;
            byte_cnt     <= 4'd0;
            accel_x      <= '0;
            accel_y      <= '0;
            accel_z      <= '0;
            temp_raw     <= '0;
            gyro_x       <= '0;
            gyro_y       <= '0;
            gyro_z       <= '0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state        <= SEND;
                        busy         <= 1'b1;
                        spi_cs_hold  <= 1'b1;
                        byte_cnt     <= 4'd0;
                        spi_tx_byte  <= READ_BIT | START_REG;
                        spi_tx_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (spi_tx_ready) begin
                        spi_tx_valid <= 1'b0;
                        state        <= WAIT_RX;
                    end
                end
                WAIT_RX: begin
                    if (spi_rx_valid) begin
                        byte_cnt <= byte_cnt + 4'd1;
                        if (byte_cnt == 4'(NUM_BYTES)) begin
                            state        <= LATCH;
                            sample_valid <= 1'b1;
                            spi_cs_hold  <= 1'b0;
                            accel_x      <= be_word(buf_next[0],  buf_next[1]);
                            accel_y      <= be_word(buf_next[2],  buf_next[3]);
                            accel_z      <= be_word(buf_next[4],  buf_next[5]);
                            temp_raw     <= be_word(buf_next[6],  buf_next[7]);
                            gyro_x       <= be_word(buf_next[8],  buf_next[9]);
                            gyro_y       <= be_word(buf_next[10], buf_next[11]);
                            gyro_z       <= be_word(buf_next[12], buf_next[13]);
                        end else begin
                            spi_tx_byte  <= DUMMY_BYTE;
                            spi_tx_valid <= 1'b1;
                            state        <= SEND;
                        end
                    end
                end
                LATCH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/imu_burst_reader.md
Name: imu_burst_reader

Overview:
Upstream/downstream partner of the SPI byte engine for the MPU9250. Issues one burst-read transaction per trigger: command byte, then NUM_BYTES dummy bytes, one byte at a time through a valid/ready handshake. Assembles the received big-endian bytes into 16-bit signed accel, temperature and gyro words. Presents all seven words together with a single-cycle sample_valid pulse.

Parameters:
START_REG, 8'h3B, first register of the burst (ACCEL_XOUT_H).
NUM_BYTES, 14, data bytes read after the command byte; fixed at 14 in this revision, other values are illegal.
SAMPLE_DIV, 12000, trigger period in clk cycles; used only with IMU_SAMPLE_TIMER_EN.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle trigger; ignored while busy
busy  out  1  high from accepted trigger until the sample_valid cycle inclusive
spi_tx_byte  out  8  byte to shift out
spi_tx_valid  out  1  tx byte valid; held stable until spi_tx_ready
spi_tx_ready  in  1  engine accepts byte when valid && ready
spi_rx_byte  in  8  byte shifted in
spi_rx_valid  in  1  one-cycle pulse per completed byte exchange
spi_cs_hold  out  1  high = engine keeps CS low between bytes
accel_x, accel_y, accel_z  out  16 each  signed
temp_raw  out  16  signed
gyro_x, gyro_y, gyro_z  out  16 each  signed
sample_valid  out  1  one-cycle pulse; all words updated in the same cycle

Behaviour:
- Reset (synchronous, active-high): state IDLE. busy, spi_tx_valid, spi_cs_hold and sample_valid are 0. spi_tx_byte and all seven data words are 0. Byte counter is 0.
- Reset mid-transaction: same result on the next edge. cs_hold drops immediately and the partial data is discarded.
- FSM states: IDLE, SEND, WAIT_RX, LATCH.
- IDLE: when start=1, go to SEND.
  - Set busy=1, spi_cs_hold=1, byte_cnt=0.
  - spi_tx_byte = 8'h80 | START_REG (the read bit).
- SEND: spi_tx_valid=1.
  - On valid && ready, drop valid and go to WAIT_RX.
- WAIT_RX: wait for spi_rx_valid.
  - If byte_cnt==0 (command echo): discard rx_byte.
  - Otherwise write rx_byte into buffer slot byte_cnt-1.
  - Increment byte_cnt.
  - If byte_cnt was NUM_BYTES, go to LATCH. Otherwise set spi_tx_byte=8'h00 and go to SEND.
  - Exactly one byte is outstanding at any time.
  - spi_rx_valid outside WAIT_RX is ignored.
- LATCH (1 cycle): load outputs from the buffer.
  - Word k = {buf[2k], buf[2k+1]}, high byte first.
  - Order: accel_x, accel_y, accel_z, temp_raw, gyro_x, gyro_y, gyro_z.
  - Drive sample_valid=1 and spi_cs_hold=0.
  - Next cycle: IDLE, busy=0.
- spi_cs_hold stays high continuously from the IDLE→SEND edge through the last WAIT_RX. It falls in LATCH.
- A start arriving in LATCH or while busy is dropped; it is not queued. A start on the cycle after LATCH is accepted.
- Minimum transaction: 15 handshakes + 15 rx pulses + 2 cycles.
- Outputs hold their last values between samples.

Optional Feature:
IMU_SAMPLE_TIMER_EN
- Defined: a free-running 32-bit counter produces an internal trigger every SAMPLE_DIV cycles.
  - The internal trigger is OR'ed with start.
  - A tick while busy is dropped.
  - The counter resets to 0 on rst.
- Undefined: no counter logic; only the start port triggers reads.

Decomposition:
- Shared package imu_pkg:
  - MPU9250 register addresses (ACCEL_XOUT_H=8'h3B, WHO_AM_I=8'h75).
  - READ_BIT=8'h80, DUMMY_BYTE=8'h00.
  - Burst length 14.
  - FSM state encoding.
- One natural sub-module: imu_sample_timer (the optional trigger counter), instantiated only under IMU_SAMPLE_TIMER_EN.

Test Plan:
- Reset then idle 20 cycles → all outputs 0, spi_tx_valid=0, spi_cs_hold=0.
- start pulse with an SPI model returning 8'hFF then bytes 8'h01..8'h0E (ready always 1):
  - First tx byte is 8'hBB, then fourteen 8'h00.
  - accel_x=16'h0102, temp_raw=16'h0708, gyro_z=16'h0D0E.
  - sample_valid is exactly 1 cycle; cs_hold falls in the same cycle.
- spi_tx_ready held low 5 cycles per byte → tx_byte and tx_valid stay stable while stalled; same results as the previous scenario.
- start re-pulsed mid-burst, plus a spurious rx_valid while in SEND → no second transaction; data unchanged.
- rst asserted after the 6th data byte → next cycle cs_hold=0, busy=0, outputs 0.
  - A fresh start then completes normally with rx bytes 8'h80,8'h00 → accel_x=16'h8000 (negative).
- With IMU_SAMPLE_TIMER_EN and SAMPLE_DIV=100 → transactions begin at cycles 100, 200, 300 after reset, with no start pulses.
